// File: rtl/des_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : des_round_ctrl_if
// Description : Handshake and datapath bundle between the DES round
//               controller, its IP/FP neighbours and the f-function.
//               master : the surrounding datapath. It drives start, decrypt,
//                        din and f_in.
//               slave  : the round controller. It drives r_out, key_idx,
//                        busy, done and dout.
// Ports       : start    1   begin a block, honoured only while idle
//               decrypt  1   1 = reverse subkey order, captured with start
//               din      64  post-IP block {L0, R0}
//               r_out    32  current R half, to the expansion stage
//               f_in     32  f-function result for r_out, same cycle
//               key_idx  4   subkey index for the current round
//               busy     1   block in progress
//               done     1   one-cycle pulse, dout valid
//               dout     64  pre-output block {R16, L16}
// Revision    : 1.0  initial release
// ============================================================================
interface des_round_ctrl_if;
    logic        start;
    logic        decrypt;
    logic [63:0] din;
    logic [31:0] r_out;
    logic [31:0] f_in;
    logic [3:0]  key_idx;
    logic        busy;
    logic        done;
    logic [63:0] dout;

    modport master (
        output start, decrypt, din, f_in,
        input  r_out, key_idx, busy, done, dout
    );

    modport slave (
        input  start, decrypt, din, f_in,
        output r_out, key_idx, busy, done, dout
    );
endinterface
`default_nettype wire

// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : des_round_ctrl
// Description : Iterative DES Feistel round controller. It holds the L/R
//               half-block registers, runs ROUNDS rounds with one round per
//               clock, and issues the subkey index in encrypt or decrypt
//               order.
// Ports       : clk  rising-edge clock
//               rst  synchronous reset, active-high
//               bus  des_round_ctrl_if.slave, which carries start, decrypt,
//                    din, f_in, r_out, key_idx, busy, done and dout
// Parameters  : ROUNDS  number of Feistel rounds per block (2..16)
// Revision    : 1.0  initial release
// ============================================================================
module des_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    des_round_ctrl_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [3:0] c_LAST    = 4'(ROUNDS - 1);

    if (ROUNDS < 2 || ROUNDS > 16) begin : g_rounds_check
        $error("des_round_ctrl: ROUNDS must be in 2..16");
    end

    logic [1:0]  r_state;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [3:0]  r_round;
    logic        r_dec;
    logic [63:0] r_dout;
    logic        r_done;
    logic        r_busy;
    logic [3:0]  r_key_idx;

    logic [3:0]  w_round_nxt;

    assign w_round_nxt = r_round + 4'd1;

    // key_idx is registered. Each write loads the index that belongs to the
    // round the counter will hold after this edge, so the index and r_out
    // always refer to the same round.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_l       <= 32'd0;
            r_r       <= 32'd0;
            r_round   <= 4'd0;
            r_dec     <= 1'b0;
            r_dout    <= 64'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_key_idx <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_l       <= bus.din[63:32];
                        r_r       <= bus.din[31:0];
                        r_round   <= 4'd0;
                        r_dec     <= bus.decrypt;
                        r_busy    <= 1'b1;
                        r_key_idx <= bus.decrypt ? c_LAST : 4'd0;
                        r_state   <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_l <= r_r;
                    r_r <= r_l ^ bus.f_in;
                    if (r_round == c_LAST) begin
                        // The counter stops here, so it never wraps.
                        r_key_idx <= 4'd0;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_round   <= w_round_nxt;
                        r_key_idx <= r_dec ? (c_LAST - w_round_nxt) : w_round_nxt;
                    end
                end
                c_ST_DONE: begin
                    // The last round leaves the halves swapped. Listing R
                    // first undoes that swap, so R16 goes in the high half.
                    r_dout  <= {r_r, r_l};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_key_idx <= 4'd0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.r_out   = r_r;
    assign bus.key_idx = r_key_idx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.dout    = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_round_ctrl
// Description : Self-checking bench for des_round_ctrl. A stand-in f-function
//               mixes r_out with a random per-index subkey. The expected
//               halves come from a Feistel reference model in this bench.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_des_round_ctrl;

    localparam int ROUNDS = 16;

    logic clk;
    logic rst;
    des_round_ctrl_if bus ();

    des_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic        f_mode;
    logic [31:0] sk [16];
    logic [63:0] last_dout;

    // Stand-in for E/key XOR/S-box/P. It is nonlinear and depends on the
    // subkey selected by key_idx, so a wrong key order changes the result.
    function automatic logic [31:0] ffun(input logic [31:0] r, input logic [31:0] k);
        logic [31:0] x;
        x = r ^ k;
        return {x[20:0], x[31:21]} ^ (x * 32'h2545F491) ^ 32'h5A5A0F0F;
    endfunction

    assign bus.f_in = f_mode ? ffun(bus.r_out, sk[bus.key_idx]) : 32'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_keys();
        for (int i = 0; i < 16; i++) sk[i] = $urandom;
    endtask

    // Runs one block and checks every cycle against the Feistel model.
    // When glitch_at is a round number, a conflicting start is pulsed
    // during that round.
    task automatic run_block(input logic [63:0] d, input logic dec,
                             input int glitch_at, output logic [63:0] got);
        logic [31:0] lm [ROUNDS+1];
        logic [31:0] rm [ROUNDS+1];
        logic [63:0] exp_dout;
        logic [3:0]  exp_k;
        int          k;
        lm[0] = d[63:32];
        rm[0] = d[31:0];
        for (int r = 0; r < ROUNDS; r++) begin
            k = dec ? (ROUNDS - 1 - r) : r;
            lm[r+1] = rm[r];
            rm[r+1] = lm[r] ^ (f_mode ? ffun(rm[r], sk[k]) : 32'd0);
        end
        exp_dout = {rm[ROUNDS], lm[ROUNDS]};

        bus.start = 1'b1; bus.din = d; bus.decrypt = dec;
        step();
        bus.start = 1'b0; bus.din = {$urandom, $urandom}; bus.decrypt = ~dec;
        for (int i = 0; i < ROUNDS; i++) begin
            exp_k = dec ? 4'(ROUNDS - 1 - i) : 4'(i);
            checks++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                errors++; $display("FAIL run_busy_done round %0d: got %b want 10", i, {bus.busy, bus.done});
            end
            checks++;
            if (bus.key_idx !== exp_k) begin
                errors++; $display("FAIL key_idx round %0d: got %0d want %0d", i, bus.key_idx, exp_k);
            end
            checks++;
            if (bus.r_out !== rm[i]) begin
                errors++; $display("FAIL r_out round %0d: got %h want %h", i, bus.r_out, rm[i]);
            end
            checks++;
            if (bus.dout !== last_dout) begin
                errors++; $display("FAIL dout_hold round %0d: got %h want %h", i, bus.dout, last_dout);
            end
            if (i == glitch_at) begin
                bus.start = 1'b1; bus.din = ~d; bus.decrypt = ~dec;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.key_idx} !== 6'b10_0000 || bus.r_out !== rm[ROUNDS]) begin
            errors++; $display("FAIL done_state: got busy %b done %b kidx %0d r_out %h want 1 0 0 %h",
                               bus.busy, bus.done, bus.key_idx, bus.r_out, rm[ROUNDS]);
        end
        step();
        checks++;
        if ({bus.busy, bus.done} !== 2'b01 || bus.dout !== exp_dout) begin
            errors++; $display("FAIL done_pulse: got busy %b done %b dout %h want 0 1 %h",
                               bus.busy, bus.done, bus.dout, exp_dout);
        end
        got = bus.dout;
        last_dout = exp_dout;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.dout !== exp_dout) begin
            errors++; $display("FAIL after_done: got done %b dout %h want 0 %h", bus.done, bus.dout, exp_dout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.din = 64'hFFFF_FFFF_FFFF_FFFF; bus.decrypt = 1'b1;
        step(); step();
        checks++;
        if ({bus.busy, bus.done, bus.key_idx} !== 6'd0 || bus.r_out !== 32'd0 || bus.dout !== 64'd0) begin
            errors++; $display("FAIL reset_state: got busy %b done %b kidx %0d r_out %h dout %h want all 0",
                               bus.busy, bus.done, bus.key_idx, bus.r_out, bus.dout);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        last_dout = 64'd0;
    endtask

    task automatic test_idle_hold();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din = {$urandom, $urandom};
            step();
            checks++;
            if (bus.busy !== 1'b0 || bus.r_out !== 32'd0 || bus.dout !== 64'd0) begin
                errors++; $display("FAIL idle_hold: got busy %b r_out %h dout %h want 0 0 0", bus.busy, bus.r_out, bus.dout);
            end
        end
    endtask

    task automatic test_zero_f();
        logic [63:0] got;
        f_mode = 1'b0;
        run_block(64'h0123456789ABCDEF, 1'b0, -1, got);
        checks++;
        if (got !== 64'h89ABCDEF01234567) begin
            errors++; $display("FAIL zero_f_swap: got %h want 89abcdef01234567", got);
        end
        f_mode = 1'b1;
    endtask

    task automatic test_random_blocks();
        logic [63:0] got;
        for (int n = 0; n < 6; n++) begin
            new_keys();
            run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, got);
        end
    endtask

    task automatic test_enc_dec();
        logic [63:0] p, c, back;
        for (int n = 0; n < 3; n++) begin
            new_keys();
            p = {$urandom, $urandom};
            run_block(p, 1'b0, -1, c);
            run_block(c, 1'b1, -1, back);
            checks++;
            if (back !== p) begin
                errors++; $display("FAIL enc_dec_roundtrip: got %h want %h", back, p);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] got;
        new_keys();
        run_block({$urandom, $urandom}, 1'b0, 5, got);
        run_block({$urandom, $urandom}, 1'b1, ROUNDS - 1, got);
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        new_keys();
        bus.start = 1'b1; bus.din = {$urandom, $urandom}; bus.decrypt = 1'b0;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_dout = 64'd0;
        checks++;
        if ({bus.busy, bus.done, bus.key_idx} !== 6'd0 || bus.r_out !== 32'd0 || bus.dout !== 64'd0) begin
            errors++; $display("FAIL reset_mid: got busy %b done %b kidx %0d r_out %h dout %h want all 0",
                               bus.busy, bus.done, bus.key_idx, bus.r_out, bus.dout);
        end
        for (int i = 0; i < ROUNDS + 4; i++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL reset_mid_quiet cycle %0d: got done %b busy %b want 0 0", i, bus.done, bus.busy);
            end
        end
        run_block({$urandom, $urandom}, 1'b1, -1, got);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d1, d2, e1, e2;
        logic [31:0] l, r, t;
        int first_t, second_t, pulses;
        logic [63:0] dout1, dout2;
        new_keys();
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        l = d1[63:32]; r = d1[31:0];
        for (int i = 0; i < ROUNDS; i++) begin t = r; r = l ^ ffun(r, sk[i]); l = t; end
        e1 = {r, l};
        l = d2[63:32]; r = d2[31:0];
        for (int i = 0; i < ROUNDS; i++) begin t = r; r = l ^ ffun(r, sk[ROUNDS-1-i]); l = t; end
        e2 = {r, l};
        first_t = -1; second_t = -1; pulses = 0; dout1 = '0; dout2 = '0;
        bus.start = 1'b1; bus.din = d1; bus.decrypt = 1'b0;
        step();
        bus.din = d2; bus.decrypt = 1'b1;
        for (int t2 = 1; t2 <= 40; t2++) begin
            step();
            if (bus.done === 1'b1) begin
                pulses++;
                if (first_t < 0) begin first_t = t2; dout1 = bus.dout; end
                else if (second_t < 0) begin second_t = t2; dout2 = bus.dout; end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first_t !== ROUNDS + 1) begin
            errors++; $display("FAIL b2b_first_latency: got %0d want %0d", first_t, ROUNDS + 1);
        end
        checks++;
        if (second_t - first_t !== ROUNDS + 2 || pulses !== 2) begin
            errors++; $display("FAIL b2b_spacing: got %0d pulses %0d want %0d pulses 2",
                               second_t - first_t, pulses, ROUNDS + 2);
        end
        checks++;
        if (dout1 !== e1 || dout2 !== e2) begin
            errors++; $display("FAIL b2b_dout: got %h %h want %h %h", dout1, dout2, e1, e2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_dout = 64'd0;
    endtask

    initial begin
        checks = 0; errors = 0; f_mode = 1'b1; last_dout = 64'd0;
        rst = 1'b1; bus.start = 1'b0; bus.decrypt = 1'b0; bus.din = 64'd0;
        for (int i = 0; i < 16; i++) sk[i] = 32'd0;
        test_reset();
        test_idle_hold();
        test_zero_f();
        test_random_blocks();
        test_enc_dec();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
